// File: rtl/gameplay_datapath_if.sv
// Strobe/status bundle between the gameplay FSM (master) and its datapath (slave).
interface gameplay_datapath_if;
   logic       ld_x;
   logic       ld_y;
   logic       ld_d;
   logic       ld_df;
   logic       enable;
   logic       save_x;
   logic       inc_row;
   logic       inc_score;
   logic       dec_chances;
   logic       c;
   logic       o;
   logic [7:0] x_pos;
   logic [6:0] y_pos;
   logic [7:0] prev_x;
   logic [3:0] row;
   logic [7:0] score;
   logic [2:0] chances;
   logic       step;

   modport master (
      output ld_x, ld_y, ld_d, ld_df, enable, save_x, inc_row, inc_score, dec_chances,
      input  c, o, x_pos, y_pos, prev_x, row, score, chances, step
   );

   modport slave (
      input  ld_x, ld_y, ld_d, ld_df, enable, save_x, inc_row, inc_score, dec_chances,
      output c, o, x_pos, y_pos, prev_x, row, score, chances, step
   );
endinterface

// File: rtl/gameplay_datapath_core.sv
// Stacker gameplay datapath: block position/bounce, rows, score, chances, move timer.
// Optional DATAPATH_PERFECT_BONUS_EN: +2 score when the block lands exactly on prev_x.
module gameplay_datapath_core #(
   parameter int X_MAX     = 160,
   parameter int BLOCK_W   = 16,
   parameter int STEP      = 4,
   parameter int ROW_H     = 8,
   parameter int Y_BASE    = 112,
   parameter int ROWS      = 15,
   parameter int CHANCES   = 3,
   parameter int TICK_BASE = 1_000_000,
   parameter int TICK_W    = 24
) (
   input  logic           clk,
   input  logic           resetn,
   gameplay_datapath_if.slave dp
);

   logic [7:0]        x_r, prev_r, score_r;
   logic [6:0]        y_r;
   logic [3:0]        row_r;
   logic [2:0]        chances_r;
   logic              dir_left, step_r;
   logic [TICK_W-1:0] cnt, period;

   logic              tick, right_hit, left_hit, move_left;
   logic [7:0]        x_moved;
   logic [1:0]        lvl;
   logic [TICK_W-1:0] period_raw, period_next;
   logic [1:0]        score_add;
   logic [8:0]        score_sum;
   logic signed [8:0] diff;
   logic [8:0]        adiff;

   // >= rather than == keeps the timer sane if the period shrinks below the current count
   assign tick = dp.enable && (cnt >= period - TICK_W'(1));

   assign right_hit = ({1'b0, x_r} + 9'(BLOCK_W) + 9'(STEP)) > 9'(X_MAX);
   assign left_hit  = x_r < 8'(STEP);
   assign move_left = dir_left ? !left_hit : right_hit;
   assign x_moved   = move_left ? x_r - 8'(STEP) : x_r + 8'(STEP);

   assign lvl         = (|score_r[7:4]) ? 2'd3 : score_r[3:2];
   assign period_raw  = TICK_W'(TICK_BASE) >> lvl;
   assign period_next = (period_raw == '0) ? TICK_W'(1) : period_raw;

`ifdef DATAPATH_PERFECT_BONUS_EN
   assign score_add = (x_r == prev_r) ? 2'd2 : 2'd1;
`else
   assign score_add = 2'd1;
`endif
   assign score_sum = {1'b0, score_r} + {7'd0, score_add};

   assign diff  = $signed({1'b0, x_r}) - $signed({1'b0, prev_r});
   assign adiff = diff[8] ? 9'(-diff) : 9'(diff);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         x_r       <= '0;
         dir_left  <= 1'b0;
         y_r       <= 7'(Y_BASE);
         prev_r    <= '0;
         row_r     <= '0;
         score_r   <= '0;
         chances_r <= 3'(CHANCES);
         period    <= TICK_W'(TICK_BASE);
         cnt       <= '0;
         step_r    <= 1'b0;
      end else begin
         if (dp.ld_x)
            cnt <= '0;
         else if (dp.enable)
            cnt <= tick ? '0 : cnt + TICK_W'(1);

         step_r <= 1'b0;
         if (dp.ld_x) begin
            x_r <= '0;
         end else if (tick && !dp.ld_d) begin
            x_r      <= x_moved;
            dir_left <= move_left;
            step_r   <= 1'b1;
         end
         if (dp.ld_d)
            dir_left <= 1'b0;

         if (dp.ld_y)
            y_r <= 7'(Y_BASE - ROW_H * int'(row_r));
         if (dp.ld_df)
            period <= period_next;
         if (dp.save_x)
            prev_r <= x_r;
         if (dp.inc_row && row_r != 4'(ROWS - 1))
            row_r <= row_r + 4'd1;
         if (dp.inc_score)
            score_r <= score_sum[8] ? 8'hFF : score_sum[7:0];
         if (dp.dec_chances && chances_r != 3'd0)
            chances_r <= chances_r - 3'd1;
      end
   end

   assign dp.x_pos   = x_r;
   assign dp.y_pos   = y_r;
   assign dp.prev_x  = prev_r;
   assign dp.row     = row_r;
   assign dp.score   = score_r;
   assign dp.chances = chances_r;
   assign dp.step    = step_r;
   assign dp.c       = chances_r != 3'd0;
   // edges exactly BLOCK_W apart are touching, not overlapping
   assign dp.o       = adiff < 9'(BLOCK_W);

endmodule

// File: tb/tb_gameplay_datapath_core.sv
// Self-checking bench: coarse instance (STEP=4, short timer) plus a 1-pixel instance for overlap edges.
module tb_gameplay_datapath_core;
   localparam int TB_TICK = 16;

   logic clk, resetn;
   int   n_chk = 0;
   int   n_err = 0;
   int   exp_q[$];

   gameplay_datapath_if bus();
   gameplay_datapath_if fbus();

   gameplay_datapath_core #(.TICK_BASE(TB_TICK)) u_dut (
      .clk(clk), .resetn(resetn), .dp(bus.slave));

   gameplay_datapath_core #(.STEP(1), .TICK_BASE(1)) u_fine (
      .clk(clk), .resetn(resetn), .dp(fbus.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic inc;
      logic dec;
      int   sc;
      int   ch;
      int   c;
   } cnt_vec_t;

   typedef struct {
      int n;
      int o;
   } ov_vec_t;

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_all(input logic v);
      bus.ld_x = v; bus.ld_y = v; bus.ld_d = v; bus.ld_df = v; bus.enable = v;
      bus.save_x = v; bus.inc_row = v; bus.inc_score = v; bus.dec_chances = v;
      fbus.ld_x = v; fbus.ld_y = v; fbus.ld_d = v; fbus.ld_df = v; fbus.enable = v;
      fbus.save_x = v; fbus.inc_row = v; fbus.inc_score = v; fbus.dec_chances = v;
   endtask

   // ld_df + ld_x + ld_d, then count enabled cycles until the first move
   task automatic measure(output int n);
      bus.ld_df = 1; bus.ld_x = 1; bus.ld_d = 1;
      tick_clk();
      bus.ld_df = 0; bus.ld_x = 0; bus.ld_d = 0;
      bus.enable = 1;
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         tick_clk();
         if (bus.step) begin
            n = k;
            break;
         end
      end
      bus.enable = 0;
   endtask

   task automatic inc_score_n(input int n);
      if (n > 0) begin
         bus.inc_score = 1;
         repeat (n) tick_clk();
         bus.inc_score = 0;
      end
   endtask

   initial begin
      cnt_vec_t tbl[5];
      ov_vec_t  ov[4];
      int first, nsteps, per, exp_sc;

      tbl[0] = '{inc: 1'b0, dec: 1'b1, sc: 0, ch: 2, c: 1};
      tbl[1] = '{inc: 1'b1, dec: 1'b1, sc: 1, ch: 1, c: 1};
      tbl[2] = '{inc: 1'b0, dec: 1'b1, sc: 1, ch: 0, c: 0};
      tbl[3] = '{inc: 1'b0, dec: 1'b1, sc: 1, ch: 0, c: 0};
      tbl[4] = '{inc: 1'b1, dec: 1'b0, sc: 2, ch: 0, c: 0};
      ov[0] = '{n: 25, o: 1};
      ov[1] = '{n: 24, o: 0};
      ov[2] = '{n: 55, o: 1};
      ov[3] = '{n: 56, o: 0};

      // reset wins over every strobe
      resetn = 0;
      set_all(1'b1);
      repeat (2) tick_clk();
      chk("rst_x", bus.x_pos, 0);
      chk("rst_y", bus.y_pos, 112);
      chk("rst_prev", bus.prev_x, 0);
      chk("rst_row", bus.row, 0);
      chk("rst_score", bus.score, 0);
      chk("rst_chances", bus.chances, 3);
      chk("rst_c", bus.c, 1);
      chk("rst_o", bus.o, 1);
      chk("rst_step", bus.step, 0);
      resetn = 1;
      set_all(1'b0);

      // full sweep right, bounce, sweep left to 0, bounce back right
      for (int i = 1; i <= 36; i++) exp_q.push_back(4 * i);
      for (int i = 35; i >= 0; i--) exp_q.push_back(4 * i);
      exp_q.push_back(4);
      exp_q.push_back(8);
      bus.ld_x = 1;
      tick_clk();
      bus.ld_x = 0;
      bus.enable = 1;
      first = -1;
      for (int cyc = 1; cyc <= 2000 && exp_q.size() > 0; cyc++) begin
         tick_clk();
         if (bus.step) begin
            if (first < 0) first = cyc;
            chk("move_x", bus.x_pos, exp_q.pop_front());
         end
      end
      bus.enable = 0;
      chk("sb_drain", exp_q.size(), 0);
      chk("first_step_cycle", first, TB_TICK);
      tick_clk();
      chk("step_one_cycle", bus.step, 0);

      nsteps = 0;
      repeat (40) begin
         tick_clk();
         if (bus.step) nsteps++;
      end
      chk("hold_steps", nsteps, 0);
      chk("hold_x", bus.x_pos, 8);

      // rows and y
      bus.inc_row = 1; tick_clk(); bus.inc_row = 0;
      chk("row_inc", bus.row, 1);
      bus.ld_y = 1; bus.inc_row = 1; tick_clk(); bus.ld_y = 0; bus.inc_row = 0;
      chk("ld_y_pre_row", bus.y_pos, 104);
      chk("row_inc2", bus.row, 2);
      bus.inc_row = 1; repeat (20) tick_clk(); bus.inc_row = 0;
      chk("row_sat", bus.row, 14);
      bus.ld_y = 1; tick_clk(); bus.ld_y = 0;
      chk("ld_y_top", bus.y_pos, 0);

      // score / chances vectors (x=8, prev=0: no bonus possible)
      for (int i = 0; i < 5; i++) begin
         bus.inc_score = tbl[i].inc;
         bus.dec_chances = tbl[i].dec;
         tick_clk();
         bus.inc_score = 0;
         bus.dec_chances = 0;
         chk("vec_score", bus.score, tbl[i].sc);
         chk("vec_chances", bus.chances, tbl[i].ch);
         chk("vec_c", bus.c, tbl[i].c);
      end

      // difficulty scaling
      inc_score_n(7);
      chk("score9", bus.score, 9);
      measure(per);
      chk("period_lvl2", per, TB_TICK >> 2);
      chk("lvl2_x", bus.x_pos, 4);
      inc_score_n(191);
      chk("score200", bus.score, 200);
      measure(per);
      chk("period_lvl3", per, TB_TICK >> 3);

      // perfect-placement bonus (build-dependent)
      bus.save_x = 1; tick_clk(); bus.save_x = 0;
      chk("save_x", bus.prev_x, 4);
      chk("o_equal", bus.o, 1);
      inc_score_n(1);
`ifdef DATAPATH_PERFECT_BONUS_EN
      exp_sc = 202;
`else
      exp_sc = 201;
`endif
      chk("score_bonus", bus.score, exp_sc);
      bus.ld_x = 1; tick_clk(); bus.ld_x = 0;
      inc_score_n(254 - exp_sc);
      chk("score254", bus.score, 254);
      bus.save_x = 1; tick_clk(); bus.save_x = 0;
      inc_score_n(1);
      chk("score_sat255", bus.score, 255);
      inc_score_n(1);
      chk("score_hold255", bus.score, 255);

      // reset mid-game beats concurrent strobes
      set_all(1'b1);
      resetn = 0;
      tick_clk();
      resetn = 1;
      set_all(1'b0);
      chk("midrst_score", bus.score, 0);
      chk("midrst_chances", bus.chances, 3);
      chk("midrst_row", bus.row, 0);
      chk("midrst_x", bus.x_pos, 0);

      // overlap boundaries on the 1-pixel instance, prev_x = 40
      fbus.ld_x = 1; tick_clk(); fbus.ld_x = 0;
      fbus.enable = 1; repeat (40) tick_clk(); fbus.enable = 0;
      chk("fine_x40", fbus.x_pos, 40);
      fbus.save_x = 1; tick_clk(); fbus.save_x = 0;
      chk("fine_prev", fbus.prev_x, 40);
      for (int i = 0; i < 4; i++) begin
         fbus.ld_x = 1; tick_clk(); fbus.ld_x = 0;
         fbus.enable = 1; repeat (ov[i].n) tick_clk(); fbus.enable = 0;
         chk("ov_x", fbus.x_pos, ov[i].n);
         chk("ov_o", fbus.o, ov[i].o);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
